// File: rtl/updn_hex_counter_pkg.sv
// Shared constants for the up/down hex counter: seven-segment glyphs
// and the elaboration-time width legality check.
package updn_hex_counter_pkg;

    // Active-low glyphs, bit order g..a; entry 0 sits in the low 7 bits.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0011000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic bit width_legal(input int w);
        return (w % 4 == 0) && (w >= 4) && (w <= 32);
    endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// One hex nibble to an active-low seven-segment glyph, or all segments off.
// Purely combinational.
module hex_seg_decode
    import updn_hex_counter_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_TABLE[nibble];
        if (blank) begin
            seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/updn_hex_counter.sv
// Up/down counter with load, programmable terminal value, wrap/saturate and
// a terminal-count pulse, driving DIGITS active-low hex displays.
module updn_hex_counter
    import updn_hex_counter_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter int               DIGITS   = WIDTH / 4,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter int               BLANK_LZ = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                up,
    input  logic                sat,
    input  logic                load,
    input  logic [WIDTH-1:0]    load_val,
    output logic [WIDTH-1:0]    count,
    output logic                tc,
    output logic                at_bound,
    output logic [7*DIGITS-1:0] seg
);

    // Enough nibbles to cover both the counter and every driven digit.
    localparam int NIBS = (DIGITS > WIDTH / 4) ? DIGITS : WIDTH / 4;

    generate
        if (!width_legal(WIDTH)) begin : g_bad_width
            $error("updn_hex_counter: WIDTH must be a multiple of 4 in 4..32");
        end
    endgenerate

    logic [WIDTH-1:0] load_clamped;
    logic             at_max;
    logic             at_zero;

    assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    assign at_max       = (count == MAX_VAL);
    assign at_zero      = (count == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count    <= '0;
            tc       <= 1'b0;
            at_bound <= 1'b0;
        end else if (load) begin
            count    <= load_clamped;
            tc       <= 1'b0;
            at_bound <= sat && ((load_clamped == '0) || (load_clamped == MAX_VAL));
        end else if (en) begin
            // Bounds are compared explicitly; MAX_VAL may sit below 2^WIDTH-1.
            if (up) begin
                if (!at_max) begin
                    count    <= count + WIDTH'(1);
                    tc       <= 1'b0;
                    at_bound <= 1'b0;
                end else if (sat) begin
                    tc       <= 1'b0;
                    at_bound <= 1'b1;
                end else begin
                    count    <= '0;
                    tc       <= 1'b1;
                    at_bound <= 1'b0;
                end
            end else begin
                if (!at_zero) begin
                    count    <= count - WIDTH'(1);
                    tc       <= 1'b0;
                    at_bound <= 1'b0;
                end else if (sat) begin
                    tc       <= 1'b0;
                    at_bound <= 1'b1;
                end else begin
                    count    <= MAX_VAL;
                    tc       <= 1'b1;
                    at_bound <= 1'b0;
                end
            end
        end else begin
            tc <= 1'b0;
        end
    end

    logic [4*NIBS-1:0] count_ext;
    logic [NIBS-1:0]   blank;
    logic              hi_zero;

    // A digit blanks only when it and every nibble above it are zero.
    always_comb begin
        count_ext              = '0;
        count_ext[WIDTH-1:0]   = count;
        blank                  = '0;
        hi_zero                = 1'b1;
        for (int i = NIBS - 1; i >= 1; i--) begin
            hi_zero  = hi_zero && (count_ext[4*i +: 4] == 4'h0);
            blank[i] = (BLANK_LZ != 0) && hi_zero;
        end
    end

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            hex_seg_decode u_dec (
                .nibble (count_ext[4*i +: 4]),
                .blank  (blank[i]),
                .seg    (seg[7*i +: 7])
            );
        end
    endgenerate

endmodule

// File: doc/updn_hex_counter.md
Name: updn_hex_counter

Overview:
- Parametrised synchronous up/down counter with parallel load, a programmable terminal value, wrap or saturate mode, and a terminal-count pulse.
- Drives DIGITS seven-segment displays (hex, active-low) with optional leading-zero blanking.
- Sits between board switches/keys and the HEX displays.
- Successor to the fixed 16-bit T-flip-flop up-counter.

Parameters:
- WIDTH, 16, counter width in bits; must be a multiple of 4, range 4..32.
- DIGITS, WIDTH/4, number of seven-segment digits driven.
- MAX_VAL, {WIDTH{1'b1}}, terminal count value; the counter range is 0..MAX_VAL.
- BLANK_LZ, 0, 1 = blank leading zero digits (digit 0 is never blanked).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- en  in  1  count enable
- up  in  1  1 = count up, 0 = count down
- sat  in  1  1 = saturate at the bounds, 0 = wrap around
- load  in  1  synchronous parallel-load strobe
- load_val  in  WIDTH  value to load
- count  out  WIDTH  current count (registered)
- tc  out  1  one-cycle terminal-count/wrap pulse (registered)
- at_bound  out  1  high while saturated at a bound (registered)
- seg  out  7*DIGITS  segments; seg[7i+6:7i] is digit i, bit order g..a, active-low

Behaviour:
- All state changes on the rising edge of clk. Priority per edge: reset low > load > en > hold.
- Reset (reset==0 at an edge): count=0, tc=0, at_bound=0. Reset mid-count or mid-load overrides everything.
- Load: count = min(load_val, MAX_VAL). tc=0. at_bound = 1 if sat and the result is 0 or MAX_VAL, else 0. Load ignores en.
- Count up (en=1, up=1):
  - count<MAX_VAL: count+1, tc=0, at_bound=0.
  - count==MAX_VAL, sat=0: count=0, tc=1 for exactly one cycle.
  - count==MAX_VAL, sat=1: hold, tc=0, at_bound=1.
- Count down (en=1, up=0):
  - count>0: count-1, tc=0, at_bound=0.
  - count==0, sat=0: count=MAX_VAL, tc=1.
  - count==0, sat=1: hold, at_bound=1.
- en=0 and load=0: count holds, tc=0, at_bound holds.
- tc is high in the same cycle the wrapped value first appears on count; it never stays high for two consecutive cycles unless a wrap occurs on two consecutive edges (possible when MAX_VAL=0).
- at_bound clears on the first edge that moves count off a bound. Toggling sat while sitting at a bound takes effect on the next enabled edge.
- Arithmetic is WIDTH-bit unsigned. No intermediate value may exceed WIDTH bits; compare against MAX_VAL, never rely on natural overflow (MAX_VAL may be below 2^WIDTH-1).
- seg is purely combinational from count (zero additional latency). Digit i decodes count[4i+3:4i] using the hex table:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- BLANK_LZ=1: a digit i>0 outputs 1111111 when its nibble and all higher nibbles are zero.
- No X on any output after the first reset edge.

Decomposition:
- Shared package: seven-segment constant table (16 entries, 7 bits), SEG_BLANK constant (7'b1111111), and the WIDTH%4 legality check.
- One sub-module: hex_seg_decode (4-bit nibble in, blank in, 7-bit seg out), instantiated DIGITS times by a generate loop.
- Counter logic stays in updn_hex_counter.

Test Plan:
- Reset: WIDTH=16, drive reset=0 for 1 edge mid-count at 0x1234 -> count=0x0000, tc=0, at_bound=0, seg digit0=1000000.
- Wrap up: MAX_VAL=0x00C7, load 0x00C6, en=1, up=1, sat=0 -> count 0x00C7, then 0x0000 with tc=1 for one cycle only.
- Wrap down and saturate: count=0, up=0, sat=0 -> 0x00C7 with tc=1. Repeat with sat=1 -> count holds at 0, at_bound=1, tc=0. Then up=1 -> count=1, at_bound=0.
- Load clamp/priority: load=1, en=1, load_val=0xFFFF with MAX_VAL=0x00C7 -> count=0x00C7. Assert reset=0 and load=1 together -> count=0.
- Display: count=0x0A5F, BLANK_LZ=0 -> digits 3..0 = 1000000, 0001000, 0010010, 0001110. With BLANK_LZ=1 and count=0x0005 -> digits 3..1 = 1111111, digit0 = 0010010.
- Hold: en=0, load=0 for 10 cycles at 0x0042 -> count stays 0x0042, tc=0 throughout.
